// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions: ALU op codes, multiply/divide op codes
// and the multiply/divide sequencer state encoding.
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_abs_fix.sv
// Sign take/restore helper: two's-complement negate when neg is set.
// Used on the operands at start and on the results in FIX.
module muldiv_abs_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? ({W{1'b0}} - val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 CALC cycles of radix-2
// shift-add or restoring division, then one FIX cycle for signs.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       md_op,
    input  logic             start,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int W = WIDTH;

    md_state_e      state_q;
    md_state_e      state_d;
    logic [4:0]     cnt_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic           neg_q;
    logic           neg_r;
    logic           div_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           go;
    logic           go_iter;
    logic           sgn_op;
    logic           a_neg;
    logic           b_neg;
    logic           b_zero;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;

    logic [W:0]     sum;
    logic [2*W-1:0] mul_nxt;
    logic [W:0]     rem;
    logic [W+1:0]   diff;
    logic [2*W-1:0] div_nxt;
    logic [2*W-1:0] step;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_hi;
    logic [W-1:0]   res_lo;

    // Request decode: Cancel always beats Start
    assign go      = (state_q == MD_IDLE) && start && !cancel;
    assign go_iter = go && (md_op <= MD_DIVU);
    assign sgn_op  = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign a_neg   = sgn_op && a_in[W-1];
    assign b_neg   = sgn_op && b_in[W-1];
    assign b_zero  = (b_in == '0);

    muldiv_abs_fix #(.W(W)) u_abs_a (
        .val (a_in),
        .neg (a_neg),
        .res (a_abs)
    );

    muldiv_abs_fix #(.W(W)) u_abs_b (
        .val (b_in),
        .neg (b_neg),
        .res (b_abs)
    );

    // One shift-add multiply step: add multiplicand on LSB, shift right
    assign sum     = {1'b0, acc_q[2*W-1:W]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_nxt = {sum, acc_q[W-1:1]};

    // One restoring divide step: shift in next dividend bit, trial subtract
    assign rem     = acc_q[2*W-1:W-1];
    assign diff    = {1'b0, rem} - {2'b00, opnd_q};
    assign div_nxt = diff[W+1]
                   ? {rem[W-1:0],  acc_q[W-2:0], 1'b0}
                   : {diff[W-1:0], acc_q[W-2:0], 1'b1};

    assign step = div_q ? div_nxt : mul_nxt;

    muldiv_abs_fix #(.W(2*W)) u_fix_prod (
        .val (acc_q),
        .neg (neg_q),
        .res (prod_fix)
    );

    muldiv_abs_fix #(.W(W)) u_fix_quo (
        .val (acc_q[W-1:0]),
        .neg (neg_q),
        .res (quo_fix)
    );

    muldiv_abs_fix #(.W(W)) u_fix_rem (
        .val (acc_q[2*W-1:W]),
        .neg (neg_r),
        .res (rem_fix)
    );

    assign res_hi = div_q ? rem_fix : prod_fix[2*W-1:W];
    assign res_lo = div_q ? quo_fix : prod_fix[W-1:0];

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Done decode
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (go_iter) begin
                    state_d = MD_CALC;
                end
            end
            MD_CALC: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == 5'd31) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                done    = !cancel;
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // CALC cycle counter, cleared outside CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 5'd0;
        end else if (state_q == MD_CALC && !cancel) begin
            cnt_q <= cnt_q + 5'd1;
        end else begin
            cnt_q <= 5'd0;
        end
    end

    // Datapath: latch magnitudes and signs at start, iterate in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_q  <= 1'b0;
        end else if (go_iter) begin
            acc_q  <= {{W{1'b0}}, a_abs};
            opnd_q <= b_abs;
            neg_q  <= md_op[1] ? ((a_neg ^ b_neg) && !b_zero)
                               : (a_neg ^ b_neg);
            neg_r  <= md_op[1] && a_neg;
            div_q  <= md_op[1];
        end else if (state_q == MD_CALC && !cancel) begin
            acc_q  <= step;
        end
    end

    // HI/LO: written by FIX completion or by mthi/mtlo in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (go && md_op == MD_MTHI) begin
            hi_q <= a_in;
        end else if (go && md_op == MD_MTLO) begin
            lo_q <= a_in;
        end
    end

    assign busy   = (state_q != MD_IDLE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations
// against an arithmetic reference model, plus cancel/reset/mthi cases.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [2:0]  md_op = '0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vectors = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .md_op  (md_op),
        .start  (start),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    // Reference model: plain integer arithmetic with MIPS special cases
    function automatic void ref_md(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] hi,
                                   output logic [31:0] lo);
        longint          sp;
        longint          sa64;
        longint          sb64;
        longint unsigned up;
        longint unsigned ua;
        int              sa;
        int              sb;
        hi = '0;
        lo = '0;
        case (op)
            MD_MULT: begin
                sa64 = longint'($signed(a));
                sb64 = longint'($signed(b));
                sp = sa64 * sb64;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            MD_MULTU: begin
                ua = {32'b0, a};
                up = ua * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    lo = 32'h80000000;
                    hi = 32'd0;
                end else begin
                    sa = $signed(a);
                    sb = $signed(b);
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFFFFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    endfunction

    // Issue one iterative op and check timing, hold and result
    task automatic do_iter_op(input logic [2:0] op,
                              input logic [31:0] a,
                              input logic [31:0] b,
                              input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        int nbusy;
        int ndone;
        int done_at;
        logic hold_bad;
        nbusy = 0;
        ndone = 0;
        done_at = -1;
        hold_bad = 1'b0;
        ref_md(op, a, b, eh, el);
        md_op = op;
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_at = k;
            end
            if (hi_out !== exp_hi || lo_out !== exp_lo) hold_bad = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (nbusy !== 33) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want 33", tag, nbusy);
        end
        vectors++;
        if (ndone !== 1 || done_at !== 33) begin
            errors++;
            $display("FAIL %s done got %0d pulses at %0d want 1 at 33",
                     tag, ndone, done_at);
        end
        vectors++;
        if (hold_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s hilo_hold changed before done", tag);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got busy=%b done=%b want 0 0",
                     tag, busy, done);
        end
        vectors++;
        if (hi_out !== eh || lo_out !== el) begin
            errors++;
            $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h",
                     tag, hi_out, lo_out, eh, el);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b want 0 0",
                     busy, done);
        end
        vectors++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo got hi=%h lo=%h want 0 0",
                     hi_out, lo_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        logic [31:0] hs  [6];
        logic [31:0] ls  [6];
        ops = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
        as  = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
                32'h80000000, 32'hFFFFFFF9};
        bs  = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd0,
                32'hFFFFFFFF, 32'd0};
        hs  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100,
                32'd0, 32'hFFFFFFF9};
        ls  = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF,
                32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 6; i++) begin
            do_iter_op(ops[i], as[i], bs[i], "directed");
            vectors++;
            if (hi_out !== hs[i] || lo_out !== ls[i]) begin
                errors++;
                $display("FAIL directed_%0d got hi=%h lo=%h want hi=%h lo=%h",
                         i, hi_out, lo_out, hs[i], ls[i]);
            end
        end
    endtask

    task automatic test_mtx();
        logic [31:0] v;
        logic [31:0] eh;
        logic [31:0] el;
        int nbusy;
        int done_at;
        md_op = MD_MTHI;
        a_in = 32'h12345678;
        start = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mthi_done got %b want 0", done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (hi_out !== 32'h12345678 || lo_out !== exp_lo || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi got hi=%h lo=%h busy=%b want %h %h 0",
                     hi_out, lo_out, busy, 32'h12345678, exp_lo);
        end
        exp_hi = 32'h12345678;
        v = $urandom;
        md_op = MD_MTLO;
        a_in = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (lo_out !== v || hi_out !== exp_hi || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b want %h %h 0",
                     hi_out, lo_out, busy, exp_hi, v);
        end
        exp_lo = v;
        for (int op = 6; op <= 7; op++) begin
            md_op = 3'(op);
            a_in = $urandom;
            b_in = $urandom;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            vectors++;
            if (busy !== 1'b0 || hi_out !== exp_hi || lo_out !== exp_lo) begin
                errors++;
                $display("FAIL noop_%0d got busy=%b hi=%h lo=%h want 0 %h %h",
                         op, busy, hi_out, lo_out, exp_hi, exp_lo);
            end
        end
        // Start during a divu must be ignored
        ref_md(MD_DIVU, 32'd1000003, 32'd17, eh, el);
        md_op = MD_DIVU;
        a_in = 32'd1000003;
        b_in = 32'd17;
        start = 1'b1;
        nbusy = 0;
        done_at = -1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (busy) nbusy++;
            if (done && done_at < 0) done_at = k;
            if (k == 5) begin
                start = 1'b1;
                md_op = MD_MTHI;
                a_in = 32'hDEADBEEF;
                b_in = 32'd0;
            end
            if (k == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        vectors++;
        if (nbusy !== 33 || done_at !== 33) begin
            errors++;
            $display("FAIL start_ignored busy=%0d done_at=%0d want 33 33",
                     nbusy, done_at);
        end
        vectors++;
        if (hi_out !== eh || lo_out !== el) begin
            errors++;
            $display("FAIL start_ignored got hi=%h lo=%h want hi=%h lo=%h",
                     hi_out, lo_out, eh, el);
        end
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic test_cancel();
        int ndone;
        for (int pass = 0; pass < 2; pass++) begin
            ndone = 0;
            md_op = MD_MULT;
            a_in = $urandom;
            b_in = $urandom;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= ((pass == 0) ? 10 : 33); k++) begin
                if ((pass == 0 && k == 10) || (pass == 1 && k == 33)) begin
                    cancel = 1'b1;
                    #1;
                end
                if (done) ndone++;
                @(posedge clk); #1;
            end
            cancel = 1'b0;
            vectors++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL cancel_%0d busy got %b want 0", pass, busy);
            end
            for (int k = 0; k < 40; k++) begin
                if (done) ndone++;
                @(posedge clk); #1;
            end
            vectors++;
            if (ndone !== 0 || hi_out !== exp_hi || lo_out !== exp_lo) begin
                errors++;
                $display("FAIL cancel_%0d done=%0d hi=%h lo=%h want 0 %h %h",
                         pass, ndone, hi_out, lo_out, exp_hi, exp_lo);
            end
        end
        md_op = MD_DIVU;
        a_in = 32'd50;
        b_in = 32'd5;
        start = 1'b1;
        cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_iter_op(op, a, b, "random");
        end
    endtask

    task automatic test_reset_mid();
        md_op = MD_MULTU;
        a_in = 32'hFFFF0001;
        b_in = 32'h0000FFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0",
                     busy, done, hi_out, lo_out);
        end
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_iter_op(MD_MULT, 32'd3, 32'd4, "rst_mult");
        vectors++;
        if (lo_out !== 32'd12 || hi_out !== 32'd0) begin
            errors++;
            $display("FAIL rst_mult got hi=%h lo=%h want 0 0000000c",
                     hi_out, lo_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mtx();
        test_cancel();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO register width; only 32 is supported.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A_in  input  32  operand rs; dividend or multiplicand; mthi/mtlo source.
REQ-005 B_in  input  32  operand rt; divisor or multiplier.
REQ-006 Md_op  input  3  operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
REQ-007 Start  input  1  single-cycle request from the EX stage; operands and Md_op are sampled in the same cycle.
REQ-008 Cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-009 Busy  output  1  high while an iterative operation is in flight; the pipeline stalls mfhi/mflo/muldiv on it.
REQ-010 Done  output  1  one-cycle pulse in the cycle HI/LO take the new result.
REQ-011 Hi_out  output  32  current HI register.
REQ-012 Lo_out  output  32  current LO register.

Function
REQ-013 Three states: IDLE, CALC, FIX.
- IDLE: Start with Md_op 0-3 moves to CALC.
- CALC: exactly 32 cycles, counted by a 5-bit counter, then moves to FIX.
- FIX: one cycle, then returns to IDLE.
REQ-014 Busy SHALL be high in CALC and FIX and low in IDLE.
- Start in cycle N with Md_op 0-3 gives Busy high in cycles N+1..N+33.
- Done and the HI/LO update occur at the end of cycle N+33.
- The result is readable from cycle N+34.
REQ-015 Signed ops (mult, div) SHALL latch the absolute values of the operands and the result sign(s) at Start; FIX applies two's-complement correction.
REQ-016 mult/multu: radix-2 shift-add, one bit per CALC cycle; {HI,LO} = full 64-bit product.
REQ-017 div/divu: restoring division, one quotient bit per CALC cycle; LO = quotient, HI = remainder.
- Quotient truncates toward zero.
- Remainder takes the sign of the dividend.
REQ-018 Division by zero SHALL still take 33 cycles and give LO = 32'hFFFFFFFF, HI = A_in, for both signed and unsigned.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give LO = 32'h80000000, HI = 0.
REQ-020 mthi/mtlo with Start in IDLE SHALL write A_in to HI/LO at that clock edge.
- Busy stays low and Done is not pulsed.
- The new value is visible the next cycle.
REQ-021 Start while Busy SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-022 Cancel in CALC or FIX SHALL return to IDLE at the next edge; HI/LO are unchanged and Done is not pulsed.
REQ-023 Cancel and Start in the same IDLE cycle: Cancel wins and nothing starts.
REQ-024 Md_op 6 or 7 with Start SHALL do nothing.
REQ-025 HI/LO change only on FIX completion, on mthi/mtlo, or on reset.

Reset
REQ-026 Rst_n low SHALL immediately force:
- state to IDLE, counter to 0;
- Busy = 0, Done = 0, HI = 0, LO = 0;
- all internal datapath registers to 0.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation; after release the unit accepts Start in the first cycle.

Structure
REQ-028 The Md_op encodings and the state encoding SHALL be constants in the shared CPU definitions package, alongside the ALU op codes.
REQ-029 The unit is one module with one optional sub-module, muldiv_abs_fix, a combinational sign take/restore helper used at Start and in FIX.
REQ-030 The datapath registers are:
- a 64-bit accumulator/remainder-quotient register;
- a 32-bit operand register;
- two sign flags.
REQ-031 Target size is 150-300 lines of RTL.

Verification
REQ-032 multu, A = 32'hFFFFFFFF, B = 32'hFFFFFFFF -> after 33 Busy cycles, HI = 32'hFFFFFFFE, LO = 32'h00000001, one Done pulse.
REQ-033 mult, A = -7, B = 3 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
REQ-034 div, A = -7, B = 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; divu, A = 100, B = 0 -> LO = 32'hFFFFFFFF, HI = 100.
REQ-035 mthi 32'h12345678 in IDLE, then a Start issued 5 cycles into a divu -> HI reads 32'h12345678 next cycle; the divu finishes unaffected at its original Done cycle.
REQ-036 Cancel in CALC cycle 10 of a mult -> Busy low next cycle, no Done pulse, HI/LO hold their prior values.
REQ-037 Rst_n pulsed low mid-CALC -> Busy, HI, LO = 0 immediately; a mult 3 x 4 started the first cycle after release gives LO = 12 at the expected cycle.
